// File: rtl/wt_cache_pkg.sv
// Shared write-through cache types and defaults.
// Holds the read-arbiter request bundle and geometry constants.
package wt_cache_pkg;

    localparam int DCACHE_TAG_WIDTH     = 44;
    localparam int DCACHE_CL_IDX_WIDTH  = 8;
    localparam int DCACHE_OFFSET_WIDTH  = 4;
    localparam int DCACHE_RD_MAX_STARVE = 7;

    typedef struct packed {
        logic [DCACHE_TAG_WIDTH-1:0]    tag;
        logic [DCACHE_CL_IDX_WIDTH-1:0] idx;
        logic [DCACHE_OFFSET_WIDTH-1:0] off;
        logic                           tag_only;
    } rd_arb_sel_t;

endpackage

// File: rtl/wt_dcache_rr_pick.sv
// One-hot round-robin pick: first set request at or after the start pointer.
// Search wraps modulo N.
module wt_dcache_rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt
);

    always_comb begin
        logic w_found;
        o_gnt   = '0;
        w_found = 1'b0;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                if (!w_found && i_req[i] &&
                    (i == (int'(i_ptr) + j) % N)) begin
                    o_gnt[i] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wt_dcache_rd_arb.sv
// Read-port arbiter and array request register for the write-through L1.
// Round-robin high class, aging promotion for low-class ports and the write port.
module wt_dcache_rd_arb
    import wt_cache_pkg::*;
#(
    parameter int NumPorts  = 4,
    parameter int MaxStarve = DCACHE_RD_MAX_STARVE,
    parameter int TagWidth  = DCACHE_TAG_WIDTH,
    parameter int IdxWidth  = DCACHE_CL_IDX_WIDTH,
    parameter int OffWidth  = DCACHE_OFFSET_WIDTH
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumPorts-1:0]                rd_req_i,
    input  logic [NumPorts-1:0]                rd_prio_i,
    input  logic [NumPorts-1:0]                rd_tag_only_i,
    input  logic [NumPorts-1:0][TagWidth-1:0]  rd_tag_i,
    input  logic [NumPorts-1:0][IdxWidth-1:0]  rd_idx_i,
    input  logic [NumPorts-1:0][OffWidth-1:0]  rd_off_i,
    output logic [NumPorts-1:0]                rd_ack_o,
    input  logic                               wr_req_i,
    output logic                               wr_ack_o,
    input  logic                               wr_cl_vld_i,
    output logic                               sel_vld_o,
    output logic [NumPorts-1:0]                sel_port_o,
    output logic [TagWidth-1:0]                sel_tag_o,
    output logic [IdxWidth-1:0]                sel_idx_o,
    output logic [OffWidth-1:0]                sel_off_o,
    output logic                               sel_tag_only_o
);

    localparam int PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int CW = $clog2(MaxStarve + 1);
    localparam int NR = NumPorts + 1;

    typedef struct packed {
        logic [TagWidth-1:0] tag;
        logic [IdxWidth-1:0] idx;
        logic [OffWidth-1:0] off;
        logic                tag_only;
    } sel_t;

    logic [CW-1:0]       r_cnt [NR];
    logic [PW-1:0]       r_rr;
    logic                r_sel_vld;
    logic [NumPorts-1:0] r_sel_port;
    sel_t                r_sel;

    logic                w_go;
    logic [NR-1:0]       w_low_req;
    logic [NR-1:0]       w_prom;
    logic [NR-1:0]       w_ack_all;
    logic [NumPorts-1:0] w_hi_req;
    logic [NumPorts-1:0] w_rr_gnt;
    logic [NumPorts-1:0] w_rd_gnt;
    logic                w_wr_gnt;
    logic                w_rr_used;
    logic [PW-1:0]       w_rr_nxt;
    sel_t                w_sel;

    assign w_go      = !wr_cl_vld_i && !rst_i;
    assign w_low_req = {wr_req_i, rd_req_i & ~rd_prio_i};
    assign w_hi_req  = rd_req_i & rd_prio_i;
    assign w_ack_all = {w_wr_gnt, w_rd_gnt};

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            w_prom[i] = w_low_req[i] && (r_cnt[i] == CW'(MaxStarve));
        end
    end

    wt_dcache_rr_pick #(
        .N  (NumPorts),
        .PW (PW)
    ) u_rr_pick (
        .i_req (w_hi_req),
        .i_ptr (r_rr),
        .o_gnt (w_rr_gnt)
    );

    // Promoted > round-robin high > fixed-order low > write.
    always_comb begin
        logic w_found;
        w_rd_gnt  = '0;
        w_wr_gnt  = 1'b0;
        w_rr_used = 1'b0;
        w_found   = 1'b0;
        if (w_go) begin
            for (int i = 0; i < NumPorts; i++) begin
                if (!w_found && w_prom[i]) begin
                    w_rd_gnt[i] = 1'b1;
                    w_found     = 1'b1;
                end
            end
            if (!w_found && w_prom[NumPorts]) begin
                w_wr_gnt = 1'b1;
                w_found  = 1'b1;
            end
            if (!w_found && (|w_hi_req)) begin
                w_rd_gnt  = w_rr_gnt;
                w_rr_used = 1'b1;
                w_found   = 1'b1;
            end
            for (int i = 0; i < NumPorts; i++) begin
                if (!w_found && w_low_req[i]) begin
                    w_rd_gnt[i] = 1'b1;
                    w_found     = 1'b1;
                end
            end
            if (!w_found && wr_req_i) begin
                w_wr_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        w_rr_nxt = r_rr;
        for (int i = 0; i < NumPorts; i++) begin
            if (w_rr_gnt[i]) begin
                w_rr_nxt = PW'((i + 1) % NumPorts);
            end
        end
    end

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (w_rd_gnt[i]) begin
                w_sel.tag      = rd_tag_i[i];
                w_sel.idx      = rd_idx_i[i];
                w_sel.off      = rd_off_i[i];
                w_sel.tag_only = rd_tag_only_i[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR; i++) begin
                r_cnt[i] <= '0;
            end
            r_rr <= '0;
        end else if (!wr_cl_vld_i) begin
            for (int i = 0; i < NR; i++) begin
                if (!w_low_req[i] || w_ack_all[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] != CW'(MaxStarve)) begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
            if (w_rr_used) begin
                r_rr <= w_rr_nxt;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sel_vld  <= 1'b0;
            r_sel_port <= '0;
            r_sel      <= '0;
        end else begin
            r_sel_vld <= |w_rd_gnt;
            if (|w_rd_gnt) begin
                r_sel_port <= w_rd_gnt;
                r_sel      <= w_sel;
            end
        end
    end

    assign rd_ack_o       = w_rd_gnt;
    assign wr_ack_o       = w_wr_gnt;
    assign sel_vld_o      = r_sel_vld;
    assign sel_port_o     = r_sel_port;
    assign sel_tag_o      = r_sel.tag;
    assign sel_idx_o      = r_sel.idx;
    assign sel_off_o      = r_sel.off;
    assign sel_tag_only_o = r_sel.tag_only;

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// Bench for wt_dcache_rd_arb: rule-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wt_dcache_rd_arb;

    localparam int N  = 4;
    localparam int MS = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [N-1:0]         req, prio, to;
    logic [N-1:0][7:0]    tag;
    logic [N-1:0][3:0]    idx;
    logic [N-1:0][1:0]    off;
    logic                 wr, wcl;
    logic [N-1:0]         ack;
    logic                 wack, sv, sto;
    logic [N-1:0]         sp;
    logic [7:0]           st;
    logic [3:0]           si;
    logic [1:0]           so;

    logic [0:0]           req1, prio1, to1, ack1, sp1;
    logic [0:0][7:0]      tag1;
    logic [0:0][3:0]      idx1;
    logic [0:0][1:0]      off1;
    logic                 wr1, wack1, sv1, sto1;
    logic [7:0]           st1;
    logic [3:0]           si1;
    logic [1:0]           so1;

    int n_chk  = 0;
    int n_pass = 0;

    wt_dcache_rd_arb #(
        .NumPorts(N), .MaxStarve(MS),
        .TagWidth(8), .IdxWidth(4), .OffWidth(2)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .rd_req_i(req), .rd_prio_i(prio), .rd_tag_only_i(to),
        .rd_tag_i(tag), .rd_idx_i(idx), .rd_off_i(off),
        .rd_ack_o(ack), .wr_req_i(wr), .wr_ack_o(wack),
        .wr_cl_vld_i(wcl), .sel_vld_o(sv), .sel_port_o(sp),
        .sel_tag_o(st), .sel_idx_o(si), .sel_off_o(so),
        .sel_tag_only_o(sto)
    );

    wt_dcache_rd_arb #(
        .NumPorts(1), .MaxStarve(1),
        .TagWidth(8), .IdxWidth(4), .OffWidth(2)
    ) dut1 (
        .clk_i(clk), .rst_i(rst),
        .rd_req_i(req1), .rd_prio_i(prio1), .rd_tag_only_i(to1),
        .rd_tag_i(tag1), .rd_idx_i(idx1), .rd_off_i(off1),
        .rd_ack_o(ack1), .wr_req_i(wr1), .wr_ack_o(wack1),
        .wr_cl_vld_i(1'b0), .sel_vld_o(sv1), .sel_port_o(sp1),
        .sel_tag_o(st1), .sel_idx_o(si1), .sel_off_o(so1),
        .sel_tag_only_o(sto1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Model state: waiting time per low requester, RR start, request register.
    int         age [N+1];
    int         rr = 0;
    logic       mv = 1'b0;
    logic [3:0] mport = '0;
    logic [7:0] mtag = '0;
    logic [3:0] midx = '0;
    logic [1:0] moff = '0;
    logic       mto = 1'b0;

    initial begin
        for (int i = 0; i <= N; i++) age[i] = 0;
        forever begin
            int   win;
            bit   rrhit;
            bit   lowreq;
            logic [3:0] eack;
            @(negedge clk);
            win   = -1;
            rrhit = 0;
            if (!rst && !wcl) begin
                for (int i = 0; i < N; i++)
                    if (win < 0 && req[i] && !prio[i] && age[i] == MS) win = i;
                if (win < 0 && wr && age[N] == MS) win = N;
                for (int j = 0; j < N; j++)
                    if (win < 0 && req[(rr + j) % N] && prio[(rr + j) % N]) begin
                        win   = (rr + j) % N;
                        rrhit = 1;
                    end
                for (int i = 0; i < N; i++)
                    if (win < 0 && req[i] && !prio[i]) win = i;
                if (win < 0 && wr) win = N;
            end
            eack = '0;
            if (win >= 0 && win < N) eack[win] = 1'b1;
            chk("m_rd_ack", 32'(ack), 32'(eack));
            chk("m_wr_ack", 32'(wack), 32'(win == N));
            chk("m_sel_vld", 32'(sv), 32'(mv));
            chk("m_sel_port", 32'(sp), 32'(mport));
            chk("m_sel_tag", 32'(st), 32'(mtag));
            chk("m_sel_idx", 32'(si), 32'(midx));
            chk("m_sel_off", 32'(so), 32'(moff));
            chk("m_sel_to", 32'(sto), 32'(mto));
            if (rst) begin
                for (int i = 0; i <= N; i++) age[i] = 0;
                rr = 0; mv = 0; mport = '0; mtag = '0;
                midx = '0; moff = '0; mto = 0;
            end else begin
                if (!wcl) begin
                    for (int i = 0; i <= N; i++) begin
                        lowreq = (i < N) ? (req[i] && !prio[i]) : wr;
                        if (!lowreq || win == i) age[i] = 0;
                        else if (age[i] < MS) age[i] = age[i] + 1;
                    end
                    if (rrhit) rr = (win + 1) % N;
                end
                mv = (win >= 0 && win < N);
                if (mv) begin
                    mport = eack;
                    mtag  = tag[win];
                    midx  = idx[win];
                    moff  = off[win];
                    mto   = to[win];
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = '0; prio = '0; wr = 0; wcl = 0;
        repeat (n) next_cycle();
    endtask

    initial begin
        rst = 1; req = '0; prio = '0; wr = 0; wcl = 0;
        for (int i = 0; i < N; i++) begin
            tag[i] = 8'(8'hA0 + i);
            idx[i] = 4'(i + 1);
            off[i] = 2'(i);
            to[i]  = (i % 2 == 1);
        end
        req1 = '0; prio1 = '0; to1 = 1'b1; wr1 = 0;
        tag1[0] = 8'h5C; idx1[0] = 4'h9; off1[0] = 2'h2;

        @(negedge clk);
        chk("rst_sel_vld", 32'(sv), 0);
        chk("rst_sel_tag", 32'(st), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst1_sel_vld", 32'(sv1), 0);
        next_cycle();
        rst = 0;

        // Round-robin between two high ports
        req = 4'b0011; prio = 4'b0011;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 4) chk("rr_ack", 32'(ack), (c % 2 == 0) ? 1 : 2);
            if (c >= 1 && c <= 4) begin
                chk("rr_sel_port", 32'(sp), (c % 2 == 1) ? 1 : 2);
                chk("rr_sel_idx", 32'(si), (c % 2 == 1) ? 1 : 2);
            end
            next_cycle();
        end
        idle(1);

        // Low-class port 3 promoted after three lost cycles
        for (int i = 0; i < N; i++) tag[i] = 8'(8'h30 + 5 * i);
        req = 4'b1011; prio = 4'b0011;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk("prom_p3", 32'(ack[3]), 32'(c == 3 || c == 7));
            if (c == 4) chk("prom_sel_tag", 32'(st), 32'h3F);
            next_cycle();
        end
        idle(1);

        // Write starvation alone
        req = 4'b0011; prio = 4'b0011; wr = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("wr_starve", 32'(wack), 32'(c == 3));
            next_cycle();
        end
        idle(1);

        // Write and port 3 promoted together: read first
        req = 4'b1011; prio = 4'b0011; wr = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("wr2_p3", 32'(ack[3]), 32'(c == 3));
            chk("wr2_wr", 32'(wack), 32'(c == 4));
            next_cycle();
        end
        idle(1);

        // Refill block after a fresh reset
        rst = 1;
        next_cycle();
        rst = 0;
        req = 4'b1011; prio = 4'b0011; wr = 1;
        for (int c = 0; c < 10; c++) begin
            wcl = (c >= 2 && c <= 6);
            @(negedge clk);
            case (c)
                0:       chk("blk_ack0", 32'(ack), 1);
                1:       chk("blk_ack1", 32'(ack), 2);
                7:       chk("blk_ack7", 32'(ack), 1);
                8:       chk("blk_ack8", 32'(ack), 8);
                9:       chk("blk_wr9", 32'(wack), 1);
                default: begin
                    chk("blk_none", 32'({ack, wack}), 0);
                    if (c >= 3) chk("blk_sel_vld", 32'(sv), 0);
                end
            endcase
            next_cycle();
        end
        idle(1);

        // Reset asserted mid-stream
        req = 4'b0110; prio = 4'b0110;
        for (int c = 0; c < 6; c++) begin
            rst = (c == 3);
            @(negedge clk);
            if (c == 2) chk("mrst_ack2", 32'(ack), 2);
            if (c == 3) chk("mrst_acks", 32'({ack, wack}), 0);
            if (c == 4) begin
                chk("mrst_sel_vld", 32'(sv), 0);
                chk("mrst_first", 32'(ack), 2);
            end
            next_cycle();
        end
        rst = 0;
        idle(1);

        // Single port: read and write alternate
        req1 = 1'b1; prio1 = 1'b0; wr1 = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("deg_rd", 32'(ack1), 32'(c % 2 == 0));
            chk("deg_wr", 32'(wack1), 32'(c % 2 == 1));
            if (c >= 1) chk("deg_sel_vld", 32'(sv1), 32'(c % 2 == 1));
            if (c == 1) chk("deg_sel_idx", 32'(si1), 9);
            next_cycle();
        end
        req1 = '0; wr1 = 0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
